// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/execute controller for the accumulator machine
module control_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [15:0]      ir,
  input  logic             acc_zero,
  input  logic             acc_neg,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_write,
  output logic             mar_sel,
  output logic             mbr_write,
  output logic             mbr_sel,
  output logic             ir_write,
  output logic             acc_write,
  output logic [1:0]       acc_sel,
  output logic [3:0]       alu_op,
  output logic             mem_we,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_F_ADDR, S_F_READ, S_F_LATCH, S_DECODE, S_M_READ,
    S_M_LATCH, S_EXEC, S_ST_MBR, S_ST_WRITE, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4, OP_LOAD = 4'h5, OP_STORE = 4'h6, OP_JUMP = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8, OP_JN  = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC, OP_CLR = 4'hD, OP_ILL = 4'hE, OP_HALT = 4'hF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic [3:0]       opcode;
  state_t           bound_state;

  // The operand field is consumed by the datapath muxes, not by the sequencer.
  logic unused_operand;
  assign unused_operand = ^ir[ADDR_W-1:0];

  assign opcode      = ir[15:12];
  assign bound_state = run ? S_F_ADDR : S_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    count_d   = retired ? count_q + CNT_W'(1) : count_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_F_ADDR;
      S_F_ADDR:  state_d = S_F_READ;
      S_F_READ:  state_d = S_F_LATCH;
      S_F_LATCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD: state_d = S_M_READ;
          OP_STORE:                      state_d = S_ST_MBR;
          OP_JUMP, OP_JZ, OP_JN, OP_NOP: state_d = bound_state;
          OP_SHL, OP_SHR, OP_CLR:        state_d = S_EXEC;
          OP_HALT:                       state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_M_READ:   state_d = S_M_LATCH;
      S_M_LATCH:  state_d = S_EXEC;
      S_EXEC:     state_d = bound_state;
      S_ST_MBR:   state_d = S_ST_WRITE;
      S_ST_WRITE: state_d = bound_state;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mar_write = 1'b0;
    mar_sel   = 1'b0;
    mbr_write = 1'b0;
    mbr_sel   = 1'b0;
    ir_write  = 1'b0;
    acc_write = 1'b0;
    acc_sel   = 2'd0;
    alu_op    = 4'b0000;
    mem_we    = 1'b0;
    retired   = 1'b0;
    case (state_q)
      S_F_ADDR:  mar_write = 1'b1;
      S_F_READ:  pc_inc    = 1'b1;
      S_F_LATCH: ir_write  = 1'b1;
      S_DECODE: begin
        // Conditional branches are the only place the ACC flags are looked at.
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_STORE: begin
            mar_sel   = 1'b1;
            mar_write = 1'b1;
          end
          OP_JUMP: begin
            pc_load = 1'b1;
            retired = 1'b1;
          end
          OP_JZ: begin
            pc_load = acc_zero;
            retired = 1'b1;
          end
          OP_JN: begin
            pc_load = acc_neg;
            retired = 1'b1;
          end
          OP_NOP, OP_HALT: retired = 1'b1;
          default: ;
        endcase
      end
      S_M_LATCH: mbr_write = 1'b1;
      S_EXEC: begin
        acc_write = 1'b1;
        retired   = 1'b1;
        case (opcode)
          OP_SUB:  alu_op = 4'b0001;
          OP_AND:  alu_op = 4'b1000;
          OP_OR:   alu_op = 4'b1001;
          OP_XOR:  alu_op = 4'b1010;
          OP_SHL:  alu_op = 4'b0100;
          OP_SHR:  alu_op = 4'b0101;
          OP_LOAD: acc_sel = 2'd1;
          OP_CLR:  acc_sel = 2'd2;
          default: ;
        endcase
      end
      S_ST_MBR: begin
        mbr_sel   = 1'b1;
        mbr_write = 1'b1;
      end
      S_ST_WRITE: begin
        mem_we  = 1'b1;
        retired = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_count = count_q;
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, run, acc_zero, acc_neg;
  logic [15:0] ir;

  logic        pc_inc, pc_load, mar_write, mar_sel, mbr_write, mbr_sel, ir_write, acc_write;
  logic [1:0]  acc_sel;
  logic [3:0]  alu_op;
  logic        mem_we, retired, halted, illegal;
  logic [15:0] instr_count;

  logic        pc_inc_s, pc_load_s, mar_write_s, mar_sel_s, mbr_write_s, mbr_sel_s, ir_write_s, acc_write_s;
  logic [1:0]  acc_sel_s;
  logic [3:0]  alu_op_s;
  logic        mem_we_s, retired_s, halted_s, illegal_s;
  logic [3:0]  instr_count_s;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .acc_zero(acc_zero), .acc_neg(acc_neg),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_write(mar_write), .mar_sel(mar_sel),
    .mbr_write(mbr_write), .mbr_sel(mbr_sel), .ir_write(ir_write), .acc_write(acc_write),
    .acc_sel(acc_sel), .alu_op(alu_op), .mem_we(mem_we), .retired(retired),
    .instr_count(instr_count), .halted(halted), .illegal(illegal)
  );

  // Narrow counter instance: exercises the wrap from all-ones back to zero quickly.
  control_sequencer #(.ADDR_W(12), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .acc_zero(acc_zero), .acc_neg(acc_neg),
    .pc_inc(pc_inc_s), .pc_load(pc_load_s), .mar_write(mar_write_s), .mar_sel(mar_sel_s),
    .mbr_write(mbr_write_s), .mbr_sel(mbr_sel_s), .ir_write(ir_write_s), .acc_write(acc_write_s),
    .acc_sel(acc_sel_s), .alu_op(alu_op_s), .mem_we(mem_we_s), .retired(retired_s),
    .instr_count(instr_count_s), .halted(halted_s), .illegal(illegal_s)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {pc_inc, pc_load, mar_write, mar_sel, mbr_write, mbr_sel, ir_write,
                    acc_write, acc_sel, alu_op, mem_we, retired};

  function automatic int lat(input logic [3:0] op);
    if (op <= 4'h5) return 7;
    if (op == 4'h6) return 6;
    if (op == 4'hA || op == 4'hB || op == 4'hD) return 5;
    return 4;
  endfunction

  // Expected controls in cycle k (1 = F_ADDR) of an instruction with opcode op.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] op, input int k, input logic az, input logic an);
    logic pci = 0, pcl = 0, mw = 0, ms = 0, bw = 0, bs = 0, iw = 0, aw = 0, mwe = 0, ret = 0;
    logic [1:0] as = 2'd0;
    logic [3:0] ao = 4'd0;
    logic exec_kind = (op <= 4'h5) || op == 4'hA || op == 4'hB || op == 4'hD;
    if (k == 1) mw = 1;
    if (k == 2) pci = 1;
    if (k == 3) iw = 1;
    if (k == 4) begin
      if (op <= 4'h6) begin mw = 1; ms = 1; end
      if (op == 4'h7) pcl = 1;
      if (op == 4'h8) pcl = az;
      if (op == 4'h9) pcl = an;
      if (op == 4'h7 || op == 4'h8 || op == 4'h9 || op == 4'hC || op == 4'hF) ret = 1;
    end
    if (op <= 4'h5 && k == 6) bw = 1;
    if (op == 4'h6 && k == 5) begin bw = 1; bs = 1; end
    if (op == 4'h6 && k == 6) begin mwe = 1; ret = 1; end
    if (exec_kind && k == lat(op)) begin
      aw = 1; ret = 1;
      as = (op == 4'h5) ? 2'd1 : (op == 4'hD) ? 2'd2 : 2'd0;
      case (op)
        4'h1: ao = 4'b0001;
        4'h2: ao = 4'b1000;
        4'h3: ao = 4'b1001;
        4'h4: ao = 4'b1010;
        4'hA: ao = 4'b0100;
        4'hB: ao = 4'b0101;
        default: ao = 4'b0000;
      endcase
    end
    return {pci, pcl, mw, ms, bw, bs, iw, aw, as, ao, mwe, ret};
  endfunction

  // Runs one whole instruction; expects the DUT to enter F_ADDR at the next clock edge.
  task automatic run_instr(input logic [15:0] ir_v, input logic az, input logic an,
                           input logic run_end, input logic rand_run);
    logic [3:0] op = ir_v[15:12];
    int L = lat(op);
    logic [15:0] e;
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      ir = ir_v; acc_zero = az; acc_neg = an;
      run = (k == L) ? run_end : (rand_run ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      e = exp_ctrl(op, k, az, an);
      n_tests++;
      if (dut_vec !== e) begin
        n_fail++;
        $display("FAIL ctrl ir=%h cycle=%0d: got %b expected %b", ir_v, k, dut_vec, e);
      end
      n_tests++;
      if (instr_count !== 16'(model_cnt) || instr_count_s !== 4'(model_cnt)) begin
        n_fail++;
        $display("FAIL count ir=%h cycle=%0d: got %h/%h expected %h", ir_v, k, instr_count, instr_count_s, 16'(model_cnt));
      end
      n_tests++;
      if (halted !== 1'b0 || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL running_flags ir=%h cycle=%0d: got halted=%b illegal=%b expected 0 0", ir_v, k, halted, illegal);
      end
      if (e[0]) model_cnt++;
    end
  endtask

  // n cycles in IDLE; run is raised only in the last one.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run = (i == n - 1);
      #1;
      n_tests++;
      if (dut_vec !== 16'h0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL idle cycle=%0d: got ctrl=%b halted=%b expected 0 0", i, dut_vec, halted);
      end
    end
  endtask

  task automatic check_halted(input int n, input logic exp_ill);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (dut_vec !== 16'h0 || halted !== 1'b1 || illegal !== exp_ill || instr_count !== 16'(model_cnt)) begin
        n_fail++;
        $display("FAIL halt cycle=%0d: got ctrl=%b halted=%b illegal=%b count=%h expected 0 1 %b %h",
                 i, dut_vec, halted, illegal, instr_count, exp_ill, 16'(model_cnt));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; run = 1'b0; ir = 16'h0; acc_zero = 1'b0; acc_neg = 1'b0;
    #1;
    n_tests++;
    if (dut_vec !== 16'h0 || halted !== 1'b0 || illegal !== 1'b0 || instr_count !== 16'h0 || instr_count_s !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ctrl=%b halted=%b illegal=%b count=%h expected all 0", dut_vec, halted, illegal, instr_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    idle(1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ir = 16'h6010; run = 1'b1;
      #1;
      n_tests++;
      if (dut_vec !== exp_ctrl(4'h6, k, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL pre_reset_store cycle=%0d: got %b expected %b", k, dut_vec, exp_ctrl(4'h6, k, 1'b0, 1'b0));
      end
    end
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (mem_we !== 1'b0 || dut_vec !== 16'h0 || instr_count !== 16'h0 || halted !== 1'b0 || illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_store step=%0d: got ctrl=%b mem_we=%b count=%h expected 0", i, dut_vec, mem_we, instr_count);
      end
      @(posedge clk);
    end
    @(negedge clk);
    reset_n = 1'b1; run = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_add();
    do_reset();
    idle(1);
    run_instr(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    n_tests++;
    if (instr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL add_count: got %h expected 0001", instr_count);
    end
  endtask

  task automatic test_jz();
    do_reset();
    idle(1);
    run_instr(16'h8123, 1'b1, 1'b0, 1'b1, 1'b0);
    run_instr(16'h8123, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(16'h9123, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr(16'h7abc, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_store();
    do_reset();
    idle(1);
    run_instr(16'h6010, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(16'h6fff, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_run_deassert();
    do_reset();
    idle(1);
    run_instr(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    run_instr(16'hC000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic       rend;
    do_reset();
    idle(1);
    for (int i = 0; i < 150; i++) begin
      op   = 4'($urandom_range(0, 13));
      rend = ($urandom_range(0, 3) != 0);
      run_instr({op, 12'($urandom)}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rend, 1'b1);
      if (!rend) idle($urandom_range(1, 3));
    end
  endtask

  task automatic test_halt();
    do_reset();
    idle(1);
    run_instr(16'hC000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(16'hE000, 1'b0, 1'b0, 1'b1, 1'b1);
    check_halted(6, 1'b1);
    do_reset();
    idle(1);
    run_instr(16'h2001, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(16'hF000, 1'b0, 1'b0, 1'b1, 1'b1);
    check_halted(6, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    idle(1);
    for (int i = 0; i < 16; i++)
      run_instr(16'hC000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i != 15), 1'b1);
    @(negedge clk);
    run = 1'b0;
    #1;
    n_tests++;
    if (instr_count_s !== 4'h0 || instr_count !== 16'd16) begin
      n_fail++;
      $display("FAIL count_wrap: got %h/%h expected 0/0010", instr_count_s, instr_count);
    end
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; ir = 16'h0; acc_zero = 1'b0; acc_neg = 1'b0;
    test_reset();
    test_add();
    test_jz();
    test_store();
    test_run_deassert();
    test_random();
    test_halt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the accumulator machine.
- Drives write enables and mux selects for the PC, MAR, MBR, IR and ACC registers, the ALU opcode and the main-memory write enable.
- Receives the IR contents and ACC status flags from the datapath.
- Sits directly upstream of the datapath registers, ALU and memory.

Parameters:
- ADDR_W, 12, width of the instruction operand field IR[11:0]; the datapath zero-extends it to 16 bits.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- run  input  1  level; while 0, the sequencer idles at instruction boundaries.
- ir  input  16  instruction register contents; opcode is ir[15:12].
- acc_zero  input  1  ACC == 0.
- acc_neg  input  1  ACC[15].
- pc_inc  output  1  PC <= PC + 1 (16-bit wrap).
- pc_load  output  1  PC <= zero-extended ir[11:0].
- mar_write  output  1  MAR write enable.
- mar_sel  output  1  0 = PC, 1 = ir[11:0].
- mbr_write  output  1  MBR write enable.
- mbr_sel  output  1  0 = memory data_out, 1 = ACC.
- ir_write  output  1  IR <= MBR-path memory data.
- acc_write  output  1  ACC write enable.
- acc_sel  output  2  0 = ALU result, 1 = MBR, 2 = 16'h0000, 3 reserved.
- alu_op  output  4  ALU opcode.
- mem_we  output  1  main-memory write enable (address from MAR, data from MBR).
- retired  output  1  one-cycle pulse in the final cycle of each instruction.
- instr_count  output  CNT_W  count of retired instructions.
- halted  output  1  sequencer stopped.
- illegal  output  1  halted on an illegal opcode.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE; instr_count = 0; halted = 0; illegal = 0.
  - Every enable output is 0; alu_op = 0; selects = 0.
  - Reset mid-instruction aborts it immediately; a pending mem_we is dropped.
- Control decoding:
  - All enables and selects are decoded from the registered state and ir.
  - The only exception: branch decisions in DECODE also use acc_zero/acc_neg sampled that cycle.
  - Any enable not listed for a state is 0.
- States and actions:
  - IDLE: if run = 1 → F_ADDR, else stay.
  - F_ADDR: mar_sel = 0, mar_write → F_READ.
  - F_READ: memory reads MAR (1-cycle synchronous latency); pc_inc → F_LATCH.
  - F_LATCH: ir_write → DECODE.
  - DECODE, by ir[15:12]:
    - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LOAD: mar_sel = 1, mar_write → M_READ.
    - 6 STORE: mar_sel = 1, mar_write → ST_MBR.
    - 7 JUMP: pc_load, retired → BOUND.
    - 8 JZ: pc_load iff acc_zero; retired → BOUND.
    - 9 JN: pc_load iff acc_neg; retired → BOUND.
    - A SHL, B SHR, D CLR → EXEC.
    - C NOP: retired → BOUND.
    - F HALT: retired → HALT.
    - E (illegal): illegal <= 1 → HALT; not retired.
  - M_READ: memory read cycle → M_LATCH.
  - M_LATCH: mbr_sel = 0, mbr_write → EXEC.
  - EXEC: acc_write, retired → BOUND.
    - alu_op: ADD 0000, SUB 0001, AND 1000, OR 1001, XOR 1010, SHL 0100, SHR 0101; acc_sel = 0.
    - LOAD: acc_sel = 1.
    - CLR: acc_sel = 2.
  - ST_MBR: mbr_sel = 1, mbr_write → ST_WRITE.
  - ST_WRITE: mem_we, retired → BOUND.
- BOUND is not a separate state. Instruction boundary: next state = F_ADDR if run = 1, else IDLE. run is sampled only at the boundary; deasserting run mid-instruction never truncates it.
- HALT: halted = 1, all enables 0, terminal until reset; run is ignored.
- Latency (cycles from F_ADDR entry to the retired cycle, inclusive):
  - ALU ops and LOAD: 7.
  - STORE: 6.
  - SHL/SHR/CLR: 5.
  - JUMP/JZ/JN/NOP/HALT: 4.
- instr_count increments on each retired pulse, wraps FFFF → 0000, and holds in HALT.
- At most one of pc_inc / pc_load is asserted in any cycle; mem_we is asserted only in ST_WRITE.

Test Plan:
- Reset mid-STORE: assert reset_n = 0 during ST_MBR → mem_we never asserts; state IDLE, instr_count = 0, all outputs 0 while reset is held.
- run = 1 with ir = 16'h0005 (ADD, address 5): F_ADDR → F_READ (pc_inc) → F_LATCH → DECODE (mar_sel = 1) → M_READ → M_LATCH → EXEC (alu_op = 0000, acc_write, retired), exactly 7 cycles; instr_count = 1.
- ir = 16'h8123 (JZ) with acc_zero = 1 → pc_load in DECODE, retired at cycle 4. Repeat with acc_zero = 0 → no pc_load; pc_inc appears only in F_READ.
- ir = 16'h6010 (STORE): mbr_sel = 1 with mbr_write, then mem_we for exactly one cycle, retired in that cycle; total 6 cycles.
- Deassert run during EXEC of an ADD → the instruction completes, then IDLE; reassert run → F_ADDR on the next cycle.
- ir = 16'hE000 → HALT with illegal = 1, halted = 1, instr_count unchanged. ir = 16'hF000 → halted = 1, illegal = 0, instr_count + 1. Preload instr_count = 16'hFFFF, retire one instruction → 16'h0000.
